load_sched8: RTL and testbench

Round-robin scheduler that shares one write port among 8 requesters. It drives the 3-bit select and the single load strobe of the 8-way demultiplexor that fans load out to an 8-register bank. A granted requester may write a bounded burst of beats before it must give up the port. Fairness comes from a rotating priority pointer that always starts just past the last owner.

---
 rtl/load_sched8.sv | 93 +++++++++
 tb/tb_load_sched8.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_sched8.sv
// rtl/load_sched8.sv - round-robin scheduler sharing one write port among 8 requesters
//
// Drives the select and load strobe of an 8-way demux feeding an 8-register bank.
// A granted requester may write up to HOLD_MAX beats before the port is released.
// The rotating priority pointer always restarts just past the previous owner.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   req   - per-requester write request (bit i = requester i)
//   last  - per-requester final-beat flag, honoured only for the current owner
//   gnt   - registered one-hot grant, zero when no owner
//   sel   - registered demux select, holds the last owner index after release
//   load  - combinational write strobe, req[owner] while owning
//   busy  - registered, high while a requester owns the port
module load_sched8 #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] last,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       load,
  output logic       busy
);

  localparam int BW = $clog2(HOLD_MAX) + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(HOLD_MAX - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]    state;
  logic [2:0]    owner;
  logic [2:0]    ptr;
  logic [BW-1:0] beat;
  logic [2:0]    winner;
  logic [2:0]    idx;
  logic          owner_req;
  logic          release_now;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + k[2:0];
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  assign owner_req = req[owner];
  assign load      = (state == OWN) && owner_req;

  // A dropped request releases without a beat; otherwise the beat in this
  // cycle is the last one if flagged or if it exhausts the hold budget.
  assign release_now = !owner_req || last[owner] || (beat == BEAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 8'h00;
      sel   <= 3'd0;
      busy  <= 1'b0;
      ptr   <= 3'd0;
      owner <= 3'd0;
      beat  <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        owner <= winner;
        sel   <= winner;
        gnt   <= 8'(1) << winner;
        busy  <= 1'b1;
        beat  <= '0;
        state <= OWN;
      end
    end else begin
      if (release_now) begin
        gnt   <= 8'h00;
        busy  <= 1'b0;
        ptr   <= owner + 3'd1;
        state <= IDLE;
      end else begin
        beat <= beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_sched8.sv
// tb/tb_load_sched8.sv - self-checking bench for load_sched8
module tb_load_sched8;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] last = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       load;
  logic       busy;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: who owns the port, how many beats it has written,
  // where the next round-robin scan starts, and the last selected index.
  bit m_own;
  int m_owner;
  int m_beats;
  int m_ptr;
  int m_sel;

  always #5 clk = ~clk;

  load_sched8 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .last(last),
    .gnt(gnt),
    .sel(sel),
    .load(load),
    .busy(busy)
  );

  function automatic logic [12:0] expected();
    logic [7:0] g;
    logic       l;
    g = m_own ? 8'(1 << m_owner) : 8'h00;
    l = m_own && req[m_owner];
    return {g, 3'(m_sel), m_own, l};
  endfunction

  task automatic model_reset();
    m_own = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_ptr = 0;
    m_sel = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (!m_own) begin
      if (req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            break;
          end
        end
        m_own = 1'b1;
        m_sel = m_owner;
        m_beats = 0;
      end
    end else begin
      if (req[m_owner]) m_beats++;
      if (!req[m_owner] || last[m_owner] || m_beats == HOLD_MAX) begin
        m_own = 1'b0;
        m_ptr = (m_owner + 1) % 8;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 8'h00;
    last = 8'h00;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic finish_idle();
    req = 8'h00;
    last = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'h00;
    last = 8'h00;
    model_reset();
    #3;
    n_checks++;
    if ({gnt, sel, busy, load} !== 13'h0)
      $display("FAIL reset_idle: got %h expected %h", {gnt, sel, busy, load}, 13'h0);
    else n_pass++;
    tick();
    req = 8'hFF;
    #3;
    n_checks++;
    if (gnt !== 8'h00 || load !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_req_held: got gnt=%h load=%b busy=%b expected 00/0/0", gnt, load, busy);
    else n_pass++;
    req = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int loads = 0;
    apply_reset();
    req = 8'h08;
    last = 8'h00;
    for (int c = 0; c < 8; c++) begin
      #3;
      n_checks++;
      if ({gnt, sel, busy, load} !== expected())
        $display("FAIL single c%0d: got %h expected %h", c, {gnt, sel, busy, load}, expected());
      else n_pass++;
      if (c >= 1 && c <= 5 && load) loads++;
      if (c == 1) begin
        n_checks++;
        if (gnt !== 8'h08 || sel !== 3'd3)
          $display("FAIL single_grant: got gnt=%h sel=%0d expected 08/3", gnt, sel);
        else n_pass++;
      end
      if (c == 5) begin
        n_checks++;
        if (busy !== 1'b0 || gnt !== 8'h00)
          $display("FAIL single_idle_gap: got busy=%b gnt=%h expected 0/00", busy, gnt);
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++;
        if (gnt !== 8'h08)
          $display("FAIL single_regrant: got gnt=%h expected 08", gnt);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (loads !== HOLD_MAX)
      $display("FAIL single_burst_len: got %0d expected %0d", loads, HOLD_MAX);
    else n_pass++;
    finish_idle();
  endtask

  task automatic test_rotation();
    int owners[$];
    apply_reset();
    req = 8'hFF;
    last = 8'hFF;
    for (int c = 0; c < 18; c++) begin
      #3;
      n_checks++;
      if ({gnt, sel, busy, load} !== expected())
        $display("FAIL rotation c%0d: got %h expected %h", c, {gnt, sel, busy, load}, expected());
      else n_pass++;
      if (busy) owners.push_back(int'(sel));
      tick();
    end
    n_checks++;
    if (owners.size() != 9)
      $display("FAIL rotation_count: got %0d expected 9", owners.size());
    else n_pass++;
    for (int i = 0; i < owners.size(); i++) begin
      n_checks++;
      if (owners[i] != i % 8)
        $display("FAIL rotation_order[%0d]: got %0d expected %0d", i, owners[i], i % 8);
      else n_pass++;
    end
    finish_idle();
  endtask

  task automatic test_early_last();
    int loads = 0;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      req  = (c <= 2) ? 8'h20 : 8'h41;
      last = (c == 2) ? 8'h20 : 8'h00;
      #3;
      n_checks++;
      if ({gnt, sel, busy, load} !== expected())
        $display("FAIL early_last c%0d: got %h expected %h", c, {gnt, sel, busy, load}, expected());
      else n_pass++;
      if (c >= 1 && c <= 3 && load) loads++;
      if (c == 3) begin
        n_checks++;
        if (gnt !== 8'h00)
          $display("FAIL early_last_release: got gnt=%h expected 00", gnt);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (gnt !== 8'h40 || sel !== 3'd6)
          $display("FAIL early_last_ptr: got gnt=%h sel=%0d expected 40/6", gnt, sel);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (loads !== 2)
      $display("FAIL early_last_beats: got %0d expected 2", loads);
    else n_pass++;
    finish_idle();
  endtask

  task automatic test_req_drop();
    apply_reset();
    last = 8'h00;
    for (int c = 0; c < 6; c++) begin
      req = (c == 0) ? 8'h04 : (c == 1) ? 8'h06 : 8'h02;
      #3;
      n_checks++;
      if ({gnt, sel, busy, load} !== expected())
        $display("FAIL req_drop c%0d: got %h expected %h", c, {gnt, sel, busy, load}, expected());
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (load !== 1'b0 || gnt !== 8'h04)
          $display("FAIL req_drop_noload: got load=%b gnt=%h expected 0/04", load, gnt);
        else n_pass++;
      end
      if (c == 3) begin
        n_checks++;
        if (busy !== 1'b0)
          $display("FAIL req_drop_idle: got busy=%b expected 0", busy);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (gnt !== 8'h02 || sel !== 3'd1)
          $display("FAIL req_drop_next: got gnt=%h sel=%0d expected 02/1", gnt, sel);
        else n_pass++;
      end
      tick();
    end
    finish_idle();
  endtask

  task automatic test_hold_and_last();
    int loads = 0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      req  = (c <= 4) ? 8'h10 : 8'h30;
      last = (c == 4) ? 8'h10 : 8'h00;
      #3;
      n_checks++;
      if ({gnt, sel, busy, load} !== expected())
        $display("FAIL hold_last c%0d: got %h expected %h", c, {gnt, sel, busy, load}, expected());
      else n_pass++;
      if (c >= 1 && c <= 5 && load) loads++;
      if (c == 5) begin
        n_checks++;
        if (busy !== 1'b0 || gnt !== 8'h00)
          $display("FAIL hold_last_release: got busy=%b gnt=%h expected 0/00", busy, gnt);
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++;
        if (gnt !== 8'h20 || sel !== 3'd5)
          $display("FAIL hold_last_ptr: got gnt=%h sel=%0d expected 20/5", gnt, sel);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (loads !== 4)
      $display("FAIL hold_last_beats: got %0d expected 4", loads);
    else n_pass++;
    finish_idle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      req  = 8'h08;
      last = (c <= 1) ? 8'h08 : 8'h00;
      #3;
      n_checks++;
      if ({gnt, sel, busy, load} !== expected())
        $display("FAIL async_pre c%0d: got %h expected %h", c, {gnt, sel, busy, load}, expected());
      else n_pass++;
      if (c < 4) tick();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 8'h00 || busy !== 1'b0 || load !== 1'b0)
      $display("FAIL async_drop: got gnt=%h busy=%b load=%b expected 00/0/0", gnt, busy, load);
    else n_pass++;
    model_reset();
    tick();
    rst_n = 1'b1;
    req = 8'h81;
    last = 8'h00;
    #3;
    n_checks++;
    if ({gnt, sel, busy, load} !== expected())
      $display("FAIL async_post_idle: got %h expected %h", {gnt, sel, busy, load}, expected());
    else n_pass++;
    tick();
    #3;
    n_checks++;
    if (gnt !== 8'h01 || sel !== 3'd0)
      $display("FAIL async_ptr_cleared: got gnt=%h sel=%0d expected 01/0", gnt, sel);
    else n_pass++;
    tick();
    finish_idle();
  endtask

  task automatic test_random();
    logic [7:0] r;
    int errs = 0;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      r = 8'($urandom) & 8'($urandom);
      if (m_own && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      req  = r;
      last = 8'($urandom) & 8'($urandom) & 8'($urandom);
      #3;
      n_checks++;
      if ({gnt, sel, busy, load} !== expected()) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random c%0d: got %h expected %h", c, {gnt, sel, busy, load}, expected());
      end else n_pass++;
      tick();
    end
    finish_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_early_last();
    test_req_drop();
    test_hold_and_last();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
